seq_div_32: RTL and testbench
=============================

Name: seq_div_32

Overview:
- Multi-cycle signed 32-bit integer divider for the processor's multdiv path.
- Accepts a one-cycle start strobe from the pipeline and sequences a radix-2 restoring-division datapath.
- Operands are converted to magnitudes, quotient bits are iterated one per cycle, and the sign is corrected on the way out.
- Publishes the quotient with a one-cycle ready pulse and a divide-by-zero exception flag.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock
- ctrl_div  input  1  start strobe; operands sampled in the same cycle
- data_operandA  input  WIDTH  dividend, two's complement
- data_operandB  input  WIDTH  divisor, two's complement
- data_result  output  WIDTH  quotient, truncated toward zero
- data_exception  output  1  1 = divide by zero for the completed operation
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in flight (PREP, ITER, FIX)

Behaviour:
- Reset (reset==0 at an edge):
  - state goes to IDLE, counter goes to 0.
  - data_result, data_exception, data_resultRDY and busy all go to 0.
  - Reset overrides ctrl_div in the same cycle.
  - Reset mid-operation discards the operation; no RDY pulse is produced.
- States: IDLE, PREP, ITER, FIX, DONE. Transitions:
  - IDLE -> PREP when ctrl_div=1.
  - PREP -> DONE if the latched divisor is 0; otherwise PREP -> ITER.
  - ITER -> FIX when counter == WIDTH-1.
  - FIX -> DONE.
  - DONE -> IDLE.
- ctrl_div accepted (any state):
  - Latch A and B; record sign_q = A[WIDTH-1] XOR B[WIDTH-1].
  - Clear data_result and data_exception to 0; go to PREP.
  - ctrl_div in a non-IDLE state aborts and restarts; the earlier operation never raises RDY.
- PREP:
  - Magnitudes are formed as |X| = X[WIDTH-1] ? (~X + 1) : X, taken modulo 2^WIDTH.
  - Remainder register cleared; counter set to 0.
  - Divide by zero: data_exception<=1, data_result<=0, go to DONE.
- ITER, one quotient bit per cycle, MSB first:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor magnitude (WIDTH+1-bit compare).
  - On no borrow, keep the difference and set the quotient LSB to 1.
  - Counter increments each cycle.
- FIX: data_result <= sign_q ? (~q + 1) : q.
- DONE: data_resultRDY=1 for exactly this one cycle; busy=0.
- Latency, with the ctrl_div cycle as cycle 0:
  - Normal operation: RDY is high in cycle WIDTH+3 (35).
  - Divide by zero: RDY is high in cycle 2.
- Output hold: data_result and data_exception hold until the next accepted ctrl_div.
- Overflow: -2^31 / -1 yields 0x80000000 with data_exception=0 (wraps, not flagged).
- Zero dividend: result 0, no exception, full latency.
- The remainder is computed internally but is not an output.

Decomposition:
- Shared constants/package:
  - State encodings (3-bit): IDLE=0, PREP=1, ITER=2, FIX=3, DONE=4.
  - Default WIDTH=32 and the ITER count.
- One sub-module: negate_32, the two's-complement negator (bitwise inversion followed by +1 increment).
  - Instantiated twice: operand magnitude in PREP, quotient sign fix in FIX.
- FSM, counter and shift/subtract datapath live in seq_div_32.

Test Plan:
1. A=100, B=7, ctrl_div pulse in cycle 0 -> data_resultRDY high only in cycle 35; data_result=0x0000000E; exception=0; busy high in cycles 1-34.
2. Sign cases:
   - A=-100, B=7 -> 0xFFFFFFF2.
   - A=100, B=-7 -> 0xFFFFFFF2.
   - A=-100, B=-7 -> 0x0000000E.
   - A=-7, B=2 -> 0xFFFFFFFD (truncation toward zero).
3. A=5, B=0 -> RDY in cycle 2; data_result=0; data_exception=1; the next op (A=6, B=3) clears the exception and returns 2.
4. Boundary operands:
   - A=0x80000000, B=0xFFFFFFFF -> 0x80000000, exception 0.
   - A=0x80000000, B=1 -> 0x80000000.
   - A=0, B=9 -> 0.
5. Restart: ctrl_div with 100/7 in cycle 0, then ctrl_div with 9/3 in cycle 10 -> single RDY pulse in cycle 45, result 3; no pulse in cycle 35.
6. Reset held low in cycle 20 of a 100/7 operation -> from the next cycle all outputs are 0 and busy=0; no RDY appears. A fresh 100/7 op afterwards completes normally in 35 cycles.

Source files
------------

// File: rtl/seq_div_32_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package seq_div_32_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;
    localparam int unsigned DIV_ITERS = DIV_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/seq_div_32_negate.sv
// Two's-complement negator: bitwise inversion followed by +1.
module negate_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] neg_o
);

    assign neg_o = (~val_i) + WIDTH'(1);

endmodule

// File: rtl/seq_div_32.sv
// Multi-cycle signed radix-2 restoring divider with divide-by-zero flag.
module seq_div_32
    import seq_div_32_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;     // dividend, becomes quotient as bits shift in
    logic [WIDTH-1:0] dvs_q;     // divisor, becomes its magnitude after PREP
    logic [WIDTH-1:0] rem_q;
    logic             sign_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;

    logic [WIDTH-1:0] neg_opnd;
    logic [WIDTH-1:0] shared_in;
    logic [WIDTH-1:0] neg_shared;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] fix_d;

    // Dividend negator, used while forming magnitudes
    negate_32 #(.WIDTH(WIDTH)) u_neg_opnd (
        .val_i (dvd_q),
        .neg_o (neg_opnd)
    );

    // Second negator serves the divisor in PREP and the quotient in FIX;
    // those states never overlap, so one instance covers both.
    assign shared_in = (state_q == ST_PREP) ? dvs_q : dvd_q;

    negate_32 #(.WIDTH(WIDTH)) u_neg_shared (
        .val_i (shared_in),
        .neg_o (neg_shared)
    );

    // Magnitudes, trial subtraction and sign fix datapath
    always_comb begin
        mag_a  = dvd_q[WIDTH-1] ? neg_opnd : dvd_q;
        mag_b  = dvs_q[WIDTH-1] ? neg_shared : dvs_q;
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        fits   = (rem_sh >= {1'b0, dvs_q});
        rem_d  = fits ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
        quo_d  = {dvd_q[WIDTH-2:0], fits};
        fix_d  = sign_q ? neg_shared : dvd_q;
    end

    // Control FSM, iteration counter and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_div) begin
                // A new start aborts whatever was in flight
                dvd_q    <= data_operandA;
                dvs_q    <= data_operandB;
                sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                result_q <= '0;
                exc_q    <= 1'b0;
                busy_q   <= 1'b1;
                state_q  <= ST_PREP;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ST_PREP: begin
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (dvs_q == '0) begin
                            exc_q    <= 1'b1;
                            result_q <= '0;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= ST_DONE;
                        end else begin
                            dvd_q   <= mag_a;
                            dvs_q   <= mag_b;
                            state_q <= ST_ITER;
                        end
                    end
                    ST_ITER: begin
                        dvd_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        result_q <= fix_d;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_seq_div_32.sv
// Self-checking bench for seq_div_32 against a signed-arithmetic reference.
module tb_seq_div_32;

    logic        clock;
    logic        reset;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    seq_div_32 dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: truncating signed division; divide by zero gives 0 + flag
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc, output int lat);
        longint sa, sb, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            res = 32'h0; exc = 1'b1; lat = 2;
        end else begin
            q   = sa / sb;
            res = q[31:0]; exc = 1'b0; lat = 35;
        end
    endtask

    // Start an op now (caller sits just after an edge) and watch until RDY
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc,
                          output int rdy_cyc, output int pulses, output int busy_bad);
        ctrl_div = 1'b1; data_operandA = a; data_operandB = b;
        rdy_cyc = -1; pulses = 0; busy_bad = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock); #1;
            ctrl_div = 1'b0;
            if (data_resultRDY === 1'b1) begin
                pulses++;
                if (rdy_cyc < 0) rdy_cyc = k;
            end
            if (busy !== (rdy_cyc < 0)) busy_bad++;
            if (rdy_cyc >= 0 && k >= rdy_cyc + 2) break;
        end
        res = data_result;
        exc = data_exception;
    endtask

    task automatic test_reset();
        reset = 1'b0; ctrl_div = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'h0)
            $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b, want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        else n_pass++;
        reset = 1'b1; ctrl_div = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0)
            $display("FAIL reset_override: got busy=%b rdy=%b, want 0 0", busy, data_resultRDY);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] res; logic exc; int rc, pc, bb;
        run_op(32'd100, 32'd7, res, exc, rc, pc, bb);
        n_checks++;
        if (res !== 32'h0000000E || exc !== 1'b0)
            $display("FAIL basic_result: got %h/%b, want 0000000e/0", res, exc);
        else n_pass++;
        n_checks++;
        if (rc != 35 || pc != 1)
            $display("FAIL basic_latency: got rdy cycle %0d pulses %0d, want 35 and 1", rc, pc);
        else n_pass++;
        n_checks++;
        if (bb != 0)
            $display("FAIL basic_busy: got %0d bad busy cycles, want 0", bb);
        else n_pass++;
    endtask

    task automatic test_signs();
        logic [31:0] ta [4] = '{-32'sd100, 32'd100, -32'sd100, -32'sd7};
        logic [31:0] tb [4] = '{32'd7, -32'sd7, -32'sd7, 32'd2};
        logic [31:0] te [4] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h0000000E, 32'hFFFFFFFD};
        logic [31:0] res; logic exc; int rc, pc, bb;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], res, exc, rc, pc, bb);
            n_checks++;
            if (res !== te[i] || exc !== 1'b0 || rc != 35)
                $display("FAIL sign_%0d: got %h/%b at cycle %0d, want %h/0 at 35",
                         i, res, exc, rc, te[i]);
            else n_pass++;
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res; logic exc; int rc, pc, bb;
        run_op(32'd5, 32'd0, res, exc, rc, pc, bb);
        n_checks++;
        if (res !== 32'h0 || exc !== 1'b1 || rc != 2 || pc != 1 || bb != 0)
            $display("FAIL div_zero: got %h/%b cycle %0d pulses %0d busybad %0d, want 0/1 cycle 2 pulses 1 busybad 0",
                     res, exc, rc, pc, bb);
        else n_pass++;
        run_op(32'd6, 32'd3, res, exc, rc, pc, bb);
        n_checks++;
        if (res !== 32'd2 || exc !== 1'b0 || rc != 35)
            $display("FAIL after_zero: got %h/%b cycle %0d, want 2/0 cycle 35", res, exc, rc);
        else n_pass++;
    endtask

    task automatic test_boundary();
        logic [31:0] ta [3] = '{32'h80000000, 32'h80000000, 32'h0};
        logic [31:0] tb [3] = '{32'hFFFFFFFF, 32'h1, 32'd9};
        logic [31:0] te [3] = '{32'h80000000, 32'h80000000, 32'h0};
        logic [31:0] res; logic exc; int rc, pc, bb;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], res, exc, rc, pc, bb);
            n_checks++;
            if (res !== te[i] || exc !== 1'b0 || rc != 35)
                $display("FAIL boundary_%0d: got %h/%b at cycle %0d, want %h/0 at 35",
                         i, res, exc, rc, te[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, eres; logic exc, eexc; int rc, pc, bb, lat;
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            model(a, b, eres, eexc, lat);
            run_op(a, b, res, exc, rc, pc, bb);
            n_checks++;
            if (res !== eres || exc !== eexc || rc != lat || pc != 1 || bb != 0)
                $display("FAIL random_%0d: a=%h b=%h got %h/%b cyc %0d p %0d bb %0d, want %h/%b cyc %0d p 1 bb 0",
                         i, a, b, res, exc, rc, pc, bb, eres, eexc, lat);
            else n_pass++;
        end
    endtask

    task automatic test_restart();
        int first = -1; int pulses = 0;
        ctrl_div = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        for (int k = 1; k <= 55; k++) begin
            @(posedge clock); #1;
            if (k == 10) begin
                ctrl_div = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3;
            end else ctrl_div = 1'b0;
            if (data_resultRDY === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        n_checks++;
        if (first != 45 || pulses != 1 || data_result !== 32'd3)
            $display("FAIL restart: got rdy cycle %0d pulses %0d res %h, want 45 1 00000003",
                     first, pulses, data_result);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic exc; int rc, pc, bb; int seen = 0;
        ctrl_div = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clock); #1;
            ctrl_div = 1'b0;
            if (k == 20) reset = 1'b0;
            if (k == 21) begin
                reset = 1'b1;
                n_checks++;
                if ({data_result, data_exception, data_resultRDY, busy} !== 35'h0)
                    $display("FAIL reset_mid_outputs: got res=%h exc=%b rdy=%b busy=%b, want all 0",
                             data_result, data_exception, data_resultRDY, busy);
                else n_pass++;
            end
            if (data_resultRDY === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0)
            $display("FAIL reset_mid_no_rdy: got %0d pulses, want 0", seen);
        else n_pass++;
        run_op(32'd100, 32'd7, res, exc, rc, pc, bb);
        n_checks++;
        if (res !== 32'h0000000E || exc !== 1'b0 || rc != 35 || pc != 1)
            $display("FAIL reset_mid_recover: got %h/%b cycle %0d pulses %0d, want 0000000e/0 35 1",
                     res, exc, rc, pc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_boundary();
        test_random();
        test_restart();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
